// File: rtl/instr_mem_loader_if.sv
// Fetch port and byte-serial loader bus of the writable instruction memory.
// master = CPU fetch stage plus boot/host byte source, slave = the memory.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] addr;
    logic [31:0]       instr;
    logic              ld_start;
    logic [ADDR_W:0]   ld_len;
    logic              ld_valid;
    logic [7:0]        ld_byte;
    logic              ld_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output addr, ld_start, ld_len, ld_valid, ld_byte,
        input  instr, ld_ready, busy, done, err
    );

    modport slave (
        input  addr, ld_start, ld_len, ld_valid, ld_byte,
        output instr, ld_ready, busy, done, err
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Writable instruction memory: combinational fetch, byte-serial little-endian
// loader, and HALT_WORD fill on reset and at the start of every load.
module instr_mem_loader #(
    parameter int          ADDR_W    = 5,
    parameter int          DEPTH     = 32,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst,
    instr_mem_loader_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              ld_ready_q, ld_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              fill, wr_en, len_legal;
    logic [31:0]       wr_word;

    assign len_legal = (bus.ld_len != '0) && (bus.ld_len <= DEPTH_W);
    // Bytes shift in from the top, so after three bytes asm_q = {b2, b1, b0}.
    assign wr_word   = {bus.ld_byte, asm_q};

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        len_d      = len_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        fill       = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ld_start) begin
                    if (len_legal) begin
                        fill       = 1'b1;
                        len_d      = bus.ld_len;
                        wr_ptr_d   = '0;
                        byte_idx_d = '0;
                        asm_d      = '0;
                        state_d    = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.ld_valid && ld_ready_q) begin
                    if (byte_idx_q == 2'd3) begin
                        wr_en      = 1'b1;
                        byte_idx_d = '0;
                        wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                        if (({1'b0, wr_ptr_q} + (ADDR_W+1)'(1)) == len_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        asm_d      = {bus.ld_byte, asm_q[23:8]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ld_ready_d = (state_d == LOAD);
        busy_d     = (state_d == LOAD);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (fill) begin
                mem_d[i] = HALT_WORD;
            end else if (wr_en && (wr_ptr_q == ADDR_W'(i))) begin
                mem_d[i] = wr_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            len_q      <= '0;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= HALT_WORD;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            len_q      <= len_d;
            ld_ready_q <= ld_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // The CPU sees halt while a load is running or past the stored depth.
    assign bus.instr = (!busy_q && ({1'b0, bus.addr} < DEPTH_W)) ? mem_q[bus.addr] : HALT_WORD;

    assign bus.ld_ready = ld_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised self-checking bench for instr_mem_loader against a word-array
// reference built directly from the byte stream.
module tb_instr_mem_loader;
    localparam int          ADDR_W = 5;
    localparam int          DEPTH  = 24;
    localparam int          NADDR  = 2**ADDR_W;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_mem_loader #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .HALT_WORD(HALT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model [NADDR];
    logic [7:0]  stim [$];

    function automatic void model_fill();
        for (int a = 0; a < NADDR; a++) model[a] = HALT;
    endfunction

    function automatic void model_load(input int len);
        model_fill();
        for (int w = 0; w < len; w++)
            model[w] = {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
    endfunction

    function automatic void random_stim(input int nbytes);
        stim.delete();
        for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
    endfunction

    // Drives one load from stim starting at a negedge; only observes, never judges.
    task automatic drive_load(input int len, input int gap, input bit poke,
                              input int chain_len, input bit skip_start,
                              output int busy_cnt, output int done_cnt,
                              output int done_lat, output int leak_cnt);
        busy_cnt = 0; done_cnt = 0; done_lat = -1; leak_cnt = 0;
        if (!skip_start) begin
            bus.ld_start = 1'b1;
            bus.ld_len   = (ADDR_W+1)'(len);
            @(negedge clk);
            bus.ld_start = 1'b0;
        end
        for (int i = 0; i < 4*len; i++) begin
            for (int g = 0; g <= gap; g++) begin
                bus.ld_valid = (g == gap);
                bus.ld_byte  = (g == gap) ? stim[i] : 8'($urandom);
                bus.ld_start = poke && (i == 2) && (g == 0) && (gap > 0);
                if (bus.ld_start) bus.ld_len = (ADDR_W+1)'(1);
                bus.addr = ADDR_W'($urandom_range(0, DEPTH-1));
                #1;
                busy_cnt += int'(bus.busy);
                done_cnt += int'(bus.done);
                if (bus.busy && bus.instr !== HALT) leak_cnt++;
                @(negedge clk);
            end
        end
        bus.ld_valid = 1'b0;
        bus.ld_start = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            #1;
            busy_cnt += int'(bus.busy);
            if (bus.done) begin
                done_cnt++;
                if (done_lat < 0) done_lat = t;
            end
            if (t == 1 && chain_len > 0) begin
                bus.ld_start = 1'b1;
                bus.ld_len   = (ADDR_W+1)'(chain_len);
                @(negedge clk);
                bus.ld_start = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_len = '0; bus.ld_byte = '0; bus.addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_fill();
        #1;
        n_cmp++; if (bus.busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ld_ready got=%b exp=0", bus.ld_ready); end
        n_cmp++; if (bus.done !== 1'b0)     begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.err !== 1'b0)      begin n_err++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        for (int a = 0; a < NADDR; a++) begin
            @(negedge clk); bus.addr = ADDR_W'(a); #1;
            n_cmp++;
            if (bus.instr !== HALT) begin n_err++; $display("FAIL reset_sweep addr=%0d got=%h exp=%h", a, bus.instr, HALT); end
        end
        $display("reset: swept %0d addresses", NADDR);
    endtask

    task automatic test_basic_load();
        int bc, dc, dl, lk;
        @(negedge clk);
        stim = '{8'h93, 8'h00, 8'h00, 8'h01, 8'h23, 8'h20, 8'h10, 8'h00};
        drive_load(2, 0, 1'b0, 0, 1'b0, bc, dc, dl, lk);
        model_load(2);
        n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL basic_done_count got=%0d exp=1", dc); end
        n_cmp++; if (dl !== 1) begin n_err++; $display("FAIL basic_done_latency got=%0d exp=1", dl); end
        n_cmp++; if (bc !== 8) begin n_err++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
        n_cmp++; if (lk !== 0) begin n_err++; $display("FAIL basic_busy_fetch_leak got=%0d exp=0", lk); end
        for (int a = 0; a < NADDR; a++) begin
            @(negedge clk); bus.addr = ADDR_W'(a); #1;
            n_cmp++;
            if (bus.instr !== model[a]) begin n_err++; $display("FAIL basic_sweep addr=%0d got=%h exp=%h", a, bus.instr, model[a]); end
        end
        @(negedge clk); bus.addr = ADDR_W'(0); #1;
        n_cmp++; if (bus.instr !== 32'h0100_0093) begin n_err++; $display("FAIL basic_addr0 got=%h exp=01000093", bus.instr); end
        @(negedge clk); bus.addr = ADDR_W'(1); #1;
        n_cmp++; if (bus.instr !== 32'h0010_2023) begin n_err++; $display("FAIL basic_addr1 got=%h exp=00102023", bus.instr); end
        $display("basic_load: busy=%0d done=%0d lat=%0d", bc, dc, dl);
    endtask

    task automatic test_stalled();
        int bc, dc, dl, lk;
        @(negedge clk);
        stim = '{8'h93, 8'h00, 8'h00, 8'h01, 8'h23, 8'h20, 8'h10, 8'h00};
        drive_load(2, 3, 1'b1, 0, 1'b0, bc, dc, dl, lk);
        model_load(2);
        n_cmp++; if (dc !== 1)  begin n_err++; $display("FAIL stall_done_count got=%0d exp=1", dc); end
        n_cmp++; if (dl !== 1)  begin n_err++; $display("FAIL stall_done_latency got=%0d exp=1", dl); end
        n_cmp++; if (bc !== 32) begin n_err++; $display("FAIL stall_busy_cycles got=%0d exp=32", bc); end
        n_cmp++; if (lk !== 0)  begin n_err++; $display("FAIL stall_busy_fetch_leak got=%0d exp=0", lk); end
        for (int a = 0; a < NADDR; a++) begin
            @(negedge clk); bus.addr = ADDR_W'(a); #1;
            n_cmp++;
            if (bus.instr !== model[a]) begin n_err++; $display("FAIL stall_sweep addr=%0d got=%h exp=%h", a, bus.instr, model[a]); end
        end
        $display("stalled: busy=%0d done=%0d lat=%0d", bc, dc, dl);
    endtask

    task automatic test_illegal();
        int bad_len [2];
        bad_len[0] = 0;
        bad_len[1] = DEPTH + 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.ld_start = 1'b1;
            bus.ld_len   = (ADDR_W+1)'(bad_len[k]);
            @(negedge clk);
            bus.ld_start = 1'b0;
            #1;
            n_cmp++; if (bus.err !== 1'b1)  begin n_err++; $display("FAIL illegal_err_pulse len=%0d got=%b exp=1", bad_len[k], bus.err); end
            n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL illegal_busy len=%0d got=%b exp=0", bad_len[k], bus.busy); end
            @(negedge clk); #1;
            n_cmp++; if (bus.err !== 1'b0)  begin n_err++; $display("FAIL illegal_err_width len=%0d got=%b exp=0", bad_len[k], bus.err); end
            n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL illegal_busy_after len=%0d got=%b exp=0", bad_len[k], bus.busy); end
            for (int a = 0; a < NADDR; a++) begin
                @(negedge clk); bus.addr = ADDR_W'(a); #1;
                n_cmp++;
                if (bus.instr !== model[a]) begin n_err++; $display("FAIL illegal_sweep addr=%0d got=%h exp=%h", a, bus.instr, model[a]); end
            end
            $display("illegal: ld_len=%0d rejected", bad_len[k]);
        end
    endtask

    task automatic test_reload();
        int bc, dc, dl, lk;
        @(negedge clk);
        random_stim(24);
        drive_load(6, 0, 1'b0, 1, 1'b0, bc, dc, dl, lk);
        n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL reload_first_done got=%0d exp=1", dc); end
        n_cmp++; if (dl !== 1) begin n_err++; $display("FAIL reload_first_latency got=%0d exp=1", dl); end
        stim = '{8'h13, 8'h00, 8'h00, 8'h00};
        drive_load(1, 0, 1'b0, 0, 1'b1, bc, dc, dl, lk);
        model_load(1);
        n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL reload_second_done got=%0d exp=1", dc); end
        n_cmp++; if (bc !== 4) begin n_err++; $display("FAIL reload_second_busy got=%0d exp=4", bc); end
        @(negedge clk); bus.addr = ADDR_W'(0); #1;
        n_cmp++; if (bus.instr !== 32'h0000_0013) begin n_err++; $display("FAIL reload_addr0 got=%h exp=00000013", bus.instr); end
        for (int a = 0; a < NADDR; a++) begin
            @(negedge clk); bus.addr = ADDR_W'(a); #1;
            n_cmp++;
            if (bus.instr !== model[a]) begin n_err++; $display("FAIL reload_sweep addr=%0d got=%h exp=%h", a, bus.instr, model[a]); end
        end
        $display("reload: 6-word load then chained 1-word load");
    endtask

    task automatic test_reset_mid_load();
        int bc, dc, dl, lk;
        int done_seen;
        @(negedge clk);
        random_stim(12);
        bus.ld_start = 1'b1;
        bus.ld_len   = (ADDR_W+1)'(3);
        @(negedge clk);
        bus.ld_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_byte  = stim[i];
            @(negedge clk);
        end
        bus.ld_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_fill();
        #1;
        n_cmp++; if (bus.busy !== 1'b0)     begin n_err++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ld_ready got=%b exp=0", bus.ld_ready); end
        done_seen = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk); #1;
            done_seen += int'(bus.done);
        end
        n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL midrst_done_count got=%0d exp=0", done_seen); end
        for (int a = 0; a < NADDR; a++) begin
            @(negedge clk); bus.addr = ADDR_W'(a); #1;
            n_cmp++;
            if (bus.instr !== HALT) begin n_err++; $display("FAIL midrst_sweep addr=%0d got=%h exp=%h", a, bus.instr, HALT); end
        end
        @(negedge clk);
        random_stim(12);
        drive_load(3, 0, 1'b0, 0, 1'b0, bc, dc, dl, lk);
        model_load(3);
        n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL midrst_reload_done got=%0d exp=1", dc); end
        for (int a = 0; a < NADDR; a++) begin
            @(negedge clk); bus.addr = ADDR_W'(a); #1;
            n_cmp++;
            if (bus.instr !== model[a]) begin n_err++; $display("FAIL midrst_reload_sweep addr=%0d got=%h exp=%h", a, bus.instr, model[a]); end
        end
        $display("reset_mid_load: aborted after 5 bytes, reload of 3 words");
    endtask

    task automatic test_random_loads();
        int bc, dc, dl, lk, len, gap;
        for (int it = 0; it < 6; it++) begin
            @(negedge clk);
            len = (it == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            gap = int'($urandom_range(0, 2));
            random_stim(4*len);
            drive_load(len, gap, (gap > 0), 0, 1'b0, bc, dc, dl, lk);
            model_load(len);
            n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL rand_done_count it=%0d got=%0d exp=1", it, dc); end
            n_cmp++; if (dl !== 1) begin n_err++; $display("FAIL rand_done_latency it=%0d got=%0d exp=1", it, dl); end
            n_cmp++; if (bc !== 4*len*(gap+1)) begin n_err++; $display("FAIL rand_busy_cycles it=%0d got=%0d exp=%0d", it, bc, 4*len*(gap+1)); end
            n_cmp++; if (lk !== 0) begin n_err++; $display("FAIL rand_busy_fetch_leak it=%0d got=%0d exp=0", it, lk); end
            for (int a = 0; a < NADDR; a++) begin
                @(negedge clk); bus.addr = ADDR_W'(a); #1;
                n_cmp++;
                if (bus.instr !== model[a]) begin n_err++; $display("FAIL rand_sweep it=%0d addr=%0d got=%h exp=%h", it, a, bus.instr, model[a]); end
            end
            $display("random_load it=%0d len=%0d gap=%0d busy=%0d", it, len, gap, bc);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_stalled();
        test_illegal();
        test_reload();
        test_reset_mid_load();
        test_random_loads();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Parametrised, writable instruction memory for the single-cycle CPU. It replaces the hard-coded instruction ROM with the following features:
- a combinational fetch port;
- a byte-serial loader FSM that assembles little-endian 32-bit words and writes a program of programmable length;
- halt-word fill on reset and before every load, so unloaded and out-of-range locations read as halt.

The block sits between the boot/host byte source and the CPU fetch stage.

## Interface
- ADDR_W, 5, fetch/write address width in words
- DEPTH, 32, number of words stored; legal range 1 to 2^ADDR_W
- HALT_WORD, 32'hFFFF_FFFF, value returned for empty, out-of-range or busy reads

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- addr  in  ADDR_W  fetch word address
- instr  out  32  fetched instruction (combinational)
- ld_start  in  1  start-load request (sampled in IDLE only)
- ld_len  in  ADDR_W+1  number of words to load, sampled with ld_start
- ld_valid  in  1  ld_byte is valid this cycle
- ld_byte  in  8  program byte stream, little-endian within each word
- ld_ready  out  1  loader accepts a byte this cycle
- busy  out  1  a load is in progress
- done  out  1  one-cycle pulse when the last word has been written
- err  out  1  one-cycle pulse when ld_start carries an illegal ld_len

## Operation
- **Storage:** DEPTH x 32 register array.
- **Reset:**
  - every word is set to HALT_WORD;
  - FSM goes to IDLE;
  - write pointer and byte index are cleared to 0;
  - ld_ready, busy, done and err are 0.
- **FSM states:** IDLE and LOAD.
- **IDLE, ld_start with 1 ≤ ld_len ≤ DEPTH:**
  - ld_len is latched;
  - the whole array is filled with HALT_WORD;
  - write pointer and byte index are cleared to 0;
  - FSM moves to LOAD.
- **IDLE, ld_start with ld_len = 0 or ld_len > DEPTH:** err pulses for one cycle; state and array are unchanged.
- **LOAD:**
  - ld_ready = 1 and busy = 1.
  - A byte is accepted when ld_valid && ld_ready.
  - Byte index k (0..3) fills bits [8k+7:8k] of the assembly register.
  - On the 4th accepted byte, the assembled word (including that byte) is written to mem[wr_ptr]; wr_ptr increments and the byte index wraps to 0.
  - When the written word is word number ld_len (wr_ptr+1 == ld_len), the FSM returns to IDLE.
  - ld_valid low holds all state; gaps of any length are legal.
  - ld_start is ignored.
- **Words beyond ld_len** remain HALT_WORD.
- **Fetch:**
  - instr = mem[addr] when busy = 0 and addr < DEPTH;
  - otherwise instr = HALT_WORD.
  - While busy, the CPU therefore sees halt.
- **Reset mid-load:** aborts the load. The array is refilled with HALT_WORD and no done pulse is issued.
- **Address width:** addr compared against DEPTH at ADDR_W+1 bits; no wrap-around of out-of-range fetch addresses.

## Timing
- **Fetch latency:** 0 cycles (combinational from addr, array contents and busy).
- **Load start:** ld_start in cycle N gives busy = ld_ready = 1 in cycle N+1. The HALT fill is visible from N+1.
- **Byte acceptance:** one byte per cycle maximum. A word of 4 consecutive valid bytes takes 4 cycles.
- **Final byte:** accepted in cycle M gives, in cycle M+1:
  - the word is readable;
  - busy = ld_ready = 0;
  - done = 1, for exactly one cycle.
- **Minimum load time:** 4·ld_len cycles after start.
- **Illegal ld_start:** err is asserted in the following cycle for one cycle.
- **Next load:** a new ld_start is accepted in the same cycle that done is high (FSM already in IDLE).
- **Registered outputs:** ld_ready, busy, done and err are all registered; none depends combinationally on inputs.

## Test plan
- **Reset and out-of-range fetch:** assert rst for 2 cycles and sweep addr 0..31 -> instr = FFFF_FFFF everywhere. With DEPTH=24, addr 24..31 -> FFFF_FFFF.
- **Basic load:** ld_start with ld_len=2, then bytes 93 00 00 01 23 20 10 00 on consecutive cycles ->
  - addr0 = 0100_0093, addr1 = 0010_2023, addr2 = FFFF_FFFF;
  - done pulses once, exactly 1 cycle after the 8th byte;
  - busy is high for 8 cycles.
- **Stalled stream:** same stream with ld_valid low for 3 cycles between every byte -> same contents; done 1 cycle after the final byte. ld_start pulsed mid-load -> ignored.
- **Illegal lengths:** ld_len=0 and ld_len=DEPTH+1 -> err single pulse each; busy stays 0; contents unchanged.
- **Reload clears tail:** load 6 words, then load 1 word 0000_0013 -> addr0 = 0000_0013, addr1..5 = FFFF_FFFF. The second ld_start is issued in the same cycle as done.
- **Reset mid-load:** rst after 5 bytes of a 3-word load -> busy = 0; no done pulse; all words FFFF_FFFF; a subsequent full load succeeds.
